// File: rtl/aes_key_expand_ctrl.sv
// aes_key_expand_ctrl
// Sequencer for AES-128 key expansion. Feeds the external single-round key
// schedule unit (rk_cur/rcon), waits RU_LAT cycles per round, captures each
// returned round key into an (NR+1)-entry store, and serves registered reads
// of that store to the cipher datapath.
//
// Handshake: start is accepted on a rising edge only while busy=0 and the
// FSM is in IDLE; key is sampled on that same edge only. done pulses for one
// cycle when every round key is stored; ready stays high until the next
// accepted start (or reset). The round unit has no handshake: rk_cur/rcon
// are held stable and rk_next is sampled RU_LAT cycles later.
//
// Optional feature: define KEY_EXP_INV_RD_EN to add the rd_inv input, which
// reads the store in reverse (decryption) order.
module aes_key_expand_ctrl #(
    parameter int NR     = 10,
    parameter int RU_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic         ready,
    output logic [127:0] rk_cur,
    output logic [31:0]  rcon,
    input  logic [127:0] rk_next,
    input  logic [3:0]   rd_addr,
`ifdef KEY_EXP_INV_RD_EN
    input  logic         rd_inv,
`endif
    output logic [127:0] rd_data
);

    localparam int CW = (RU_LAT > 1) ? $clog2(RU_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [3:0]     round;
    logic [7:0]     rc;
    logic [127:0]   rk [0:NR];

    logic [3:0]     rd_idx;
    logic           rd_ok;

    // GF(2^8) doubling used to step the round constant.
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    // The round unit sees the round constant in the top byte.
    assign rcon = {rc, 24'h0};

    // Expansion FSM, round-key store and all control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            round  <= '0;
            rc     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            ready  <= 1'b0;
            rk_cur <= '0;
            for (int i = 0; i <= NR; i++) begin
                rk[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rk[0]  <= key;
                        rk_cur <= key;
                        rc     <= 8'h01;
                        round  <= 4'd1;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        ready  <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == CW'(RU_LAT - 1)) begin
                        rk[round] <= rk_next;
                        rk_cur    <= rk_next;
                        cnt       <= '0;
                        round     <= round + 4'd1;
                        if (round == 4'(NR)) begin
                            // Last round: keep rc as-is; it is cleared in DONE.
                            state <= DONE;
                        end else begin
                            rc <= xtime(rc);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    rc    <= 8'h00;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read index: forward order, or mirrored when reverse reads are enabled.
    always_comb begin
        rd_ok  = (rd_addr <= 4'(NR));
        rd_idx = rd_addr;
`ifdef KEY_EXP_INV_RD_EN
        if (rd_inv) begin
            rd_idx = 4'(NR) - rd_addr;
        end
`endif
    end

    // Registered read port, active every cycle regardless of busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_ok ? rk[rd_idx] : 128'h0;
        end
    end

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// tb_aes_key_expand_ctrl
// Directed bench for aes_key_expand_ctrl. Contains a behavioural AES-128
// round key unit (one register stage, matching a 2-cycle hold) driven by
// the DUT's rk_cur/rcon. Build with KEY_EXP_INV_RD_EN to cover reverse reads.
module tb_aes_key_expand_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic         ready;
    logic [127:0] rk_cur;
    logic [31:0]  rcon;
    logic [127:0] rk_next;
    logic [3:0]   rd_addr;
    logic [127:0] rd_data;
`ifdef KEY_EXP_INV_RD_EN
    logic         rd_inv;
`endif

    int tests = 0;
    int fails = 0;

    logic [127:0] exp_q [$];
    logic [127:0] fips_rk [0:10];
    logic [127:0] model_rk [0:10];
    logic [7:0]   rc_tab [0:9];
    logic [127:0] rk_pipe;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] OTHER_KEY = 128'h00112233445566778899aabbccddeeff;

    aes_key_expand_ctrl #(.NR(10), .RU_LAT(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .key     (key),
        .busy    (busy),
        .done    (done),
        .ready   (ready),
        .rk_cur  (rk_cur),
        .rcon    (rcon),
        .rk_next (rk_next),
        .rd_addr (rd_addr),
`ifdef KEY_EXP_INV_RD_EN
        .rd_inv  (rd_inv),
`endif
        .rd_data (rd_data)
    );

    // Clock
    always #5 clk = ~clk;

    // ---------------- round key unit model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b  = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] key_round(input logic [127:0] k, input logic [31:0] rc);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ rc;
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // One register stage: output valid RU_LAT=2 cycles after rk_cur/rcon change.
    always @(posedge clk) rk_pipe <= key_round(rk_cur, rcon);
    assign rk_next = rk_pipe;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start an expansion and watch it cycle by cycle. Optionally inject a
    // start with a different key at +5 (busy) and at the DONE cycle.
    task automatic run_expansion(input logic [127:0] k, input bit inj_busy, input bit inj_done);
        int done_at;
        @(negedge clk);
        key   = k;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        key   = ~k;
        check("accept_busy", 128'(busy), 128'd1);
        check("accept_ready_clr", 128'(ready), 128'd0);
        check("rcon_c0", 128'(rcon), 128'h01000000);
        done_at = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (c <= 19) check($sformatf("rcon_c%0d", c), 128'(rcon), 128'({rc_tab[c/2], 24'h0}));
            if (c <= 20) check($sformatf("busy_c%0d", c), 128'(busy), 128'd1);
            if (done === 1'b1 && done_at == 0) done_at = c;
            if (c == 21) begin
                check("rcon_idle", 128'(rcon), 128'd0);
                check("ready_at_done", 128'(ready), 128'd1);
                check("busy_at_done", 128'(busy), 128'd0);
            end
            if (c == 22) begin
                check("done_pulse_width", 128'(done), 128'd0);
                check("busy_after_done", 128'(busy), 128'd0);
                check("ready_hold", 128'(ready), 128'd1);
            end
            if (inj_busy && c == 5) begin start = 1'b1; key = OTHER_KEY; end
            if (inj_busy && c == 6) start = 1'b0;
            if (inj_done && c == 20) begin start = 1'b1; key = OTHER_KEY; end
            if (inj_done && c == 21) start = 1'b0;
        end
        check("done_latency", 128'(done_at), 128'd21);
    endtask

    // Read rd_addr 0..10 and compare against the expected queue.
    task automatic read_all(input string tag);
        logic [127:0] e;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            rd_addr = 4'(i);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            check($sformatf("%s_rk%0d", tag, i), rd_data, e);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst = 1'b1; start = 1'b0; key = '0; rd_addr = '0;
`ifdef KEY_EXP_INV_RD_EN
        rd_inv = 1'b0;
`endif
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_ready", 128'(ready), 128'd0);
        check("rst_rk_cur", rk_cur, 128'd0);
        check("rst_rcon", 128'(rcon), 128'd0);
        check("rst_rd_data", rd_data, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // Test 1: FIPS-197 key, full schedule and timing
        run_expansion(FIPS_KEY, 1'b0, 1'b0);
        check("rk_cur_keeps_last", rk_cur, fips_rk[10]);
        for (int i = 0; i <= 10; i++) exp_q.push_back(fips_rk[i]);
        read_all("t1");

        // Test 3: start during busy and during DONE ignored; restart from ready=1
        run_expansion(FIPS_KEY, 1'b1, 1'b1);
        for (int i = 0; i <= 10; i++) exp_q.push_back(fips_rk[i]);
        read_all("t3");

`ifdef KEY_EXP_INV_RD_EN
        // Test 6: reverse-order reads
        @(negedge clk); rd_inv = 1'b1; rd_addr = 4'd0;
        @(posedge clk); #1; check("inv_rd0", rd_data, fips_rk[10]);
        @(negedge clk); rd_addr = 4'd10;
        @(posedge clk); #1; check("inv_rd10", rd_data, fips_rk[0]);
        @(negedge clk); rd_addr = 4'd3;
        @(posedge clk); #1; check("inv_rd3", rd_data, fips_rk[7]);
        @(negedge clk); rd_addr = 4'd12;
        @(posedge clk); #1; check("inv_rd12", rd_data, 128'd0);
        @(negedge clk); rd_inv = 1'b0;
`endif

        // Test 4: reset at +10 cycles aborts; store cleared
        @(negedge clk);
        key = OTHER_KEY; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_ready", 128'(ready), 128'd0);
        check("abort_done", 128'(done), 128'd0);
        check("abort_rd_data", rd_data, 128'd0);
        check("abort_rcon", 128'(rcon), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        rd_addr = 4'd1;
        @(posedge clk); #1;
        check("cleared_rk1", rd_data, 128'd0);
        @(negedge clk); rd_addr = 4'd0;
        @(posedge clk); #1;
        check("cleared_rk0", rd_data, 128'd0);

        // New start after abort with a different key; expectations from the model
        model_rk[0] = OTHER_KEY;
        for (int i = 1; i <= 10; i++) model_rk[i] = key_round(model_rk[i-1], {rc_tab[i-1], 24'h0});
        run_expansion(OTHER_KEY, 1'b0, 1'b0);
        for (int i = 0; i <= 10; i++) exp_q.push_back(model_rk[i]);
        read_all("t4");

        // Test 5: out-of-range addresses and read latency
        for (int a = 11; a <= 15; a++) begin
            @(negedge clk); rd_addr = 4'(a);
            @(posedge clk); #1;
            check($sformatf("oob_rd%0d", a), rd_data, 128'd0);
        end
        @(negedge clk); rd_addr = 4'd10;
        @(posedge clk); #1;
        check("lat_rd10", rd_data, model_rk[10]);
        @(negedge clk); rd_addr = 4'd0;
        #1;
        check("lat_before_edge", rd_data, model_rk[10]);
        @(posedge clk); #1;
        check("lat_rd0_key", rd_data, OTHER_KEY);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        fails++;
        $display("FAIL timeout: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
